// File: rtl/core_ctrl.sv
// ============================================================================
// core_ctrl : multi-cycle RV32I control sequencer (FETCH/DECODE/EXECUTE/
//             MEMORY/WRITEBACK/HALT). Optional CTRL_MEM_TIMEOUT_EN adds a
//             memory-handshake watchdog.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module core_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  branch_taken,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ir_write,
  output logic [2:0]            imm_op,
  output logic                  alu_src_b,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  pc_write,
  output logic [1:0]            pc_sel,
  output logic                  halted,
  output logic                  fault
);

  // Immediate-select encodings shared with signext.
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_3120 = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_SYS, C_ILL
  } cls_t;

  if (DATA_WIDTH != 32 || MEM_TIMEOUT < 1) begin : g_param_check
    $error("core_ctrl: unsupported parameter value");
  end

  state_t     state;
  cls_t       r_cls;
  logic [2:0] r_imm;
  logic       r_asb;
  logic [1:0] r_wbs;
  logic       r_rd_nz;
  logic       r_halted;
  logic       r_fault;

  cls_t       d_cls;
  logic [2:0] d_imm;
  logic       d_asb;
  logic [1:0] d_wbs;
  logic       w_req;
  logic       w_timeout;
  logic       unused_bits;

  assign unused_bits = ^instr[DATA_WIDTH-1:12];

  always_comb begin
    d_cls = C_ILL;
    d_imm = IMM_NONE;
    d_asb = 1'b0;
    d_wbs = 2'd0;
    case (instr[6:0])
      7'b0000011: begin d_cls = C_LOAD;   d_imm = IMM_3120; d_asb = 1'b1; d_wbs = 2'd1; end
      7'b0010011: begin d_cls = C_ALU;    d_imm = IMM_3120; d_asb = 1'b1; end
      7'b1100111: begin d_cls = C_JALR;   d_imm = IMM_3120; d_asb = 1'b1; d_wbs = 2'd2; end
      7'b0100011: begin d_cls = C_STORE;  d_imm = IMM_S;    d_asb = 1'b1; end
      7'b1100011: begin d_cls = C_BRANCH; d_imm = IMM_B;    end
      7'b0110111,
      7'b0010111: begin d_cls = C_ALU;    d_imm = IMM_U;    d_asb = 1'b1; end
      7'b1101111: begin d_cls = C_JAL;    d_imm = IMM_J;    d_asb = 1'b1; d_wbs = 2'd2; end
      7'b0110011: begin d_cls = C_ALU;    end
      7'b1110011: begin d_cls = C_SYS;    end
      default:    begin d_cls = C_ILL;    end
    endcase
  end

  assign w_req = (state == S_FETCH) || (state == S_MEMORY);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Fires on the last tolerated wait cycle so the request lasts MEM_TIMEOUT cycles.
  assign w_timeout = w_req && !mem_ack && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_req && !mem_ack && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      r_cls    <= C_ALU;
      r_imm    <= IMM_NONE;
      r_asb    <= 1'b0;
      r_wbs    <= 2'd0;
      r_rd_nz  <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            state <= S_DECODE;
          end else if (w_timeout) begin
            state    <= S_HALT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end
        end
        S_DECODE: begin
          r_cls   <= d_cls;
          r_imm   <= d_imm;
          r_asb   <= d_asb;
          r_wbs   <= d_wbs;
          r_rd_nz <= |instr[11:7];
          if (d_cls == C_SYS) begin
            state    <= S_HALT;
            r_halted <= 1'b1;
          end else if (d_cls == C_ILL) begin
            state    <= S_HALT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (r_cls == C_BRANCH) begin
            state <= S_FETCH;
          end else if (r_cls == C_LOAD || r_cls == C_STORE) begin
            state <= S_MEMORY;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (mem_ack) begin
            state <= (r_cls == C_LOAD) ? S_WRITEBACK : S_FETCH;
          end else if (w_timeout) begin
            state    <= S_HALT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low throughout reset, whatever state was interrupted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    imm_op    = IMM_NONE;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    pc_write  = 1'b0;
    pc_sel    = 2'd0;
    halted    = 1'b0;
    fault     = 1'b0;
    if (!rst) begin
      mem_req   = w_req;
      mem_we    = (state == S_MEMORY) && (r_cls == C_STORE);
      ir_write  = (state == S_FETCH) && mem_ack;
      imm_op    = (state == S_DECODE) ? d_imm : r_imm;
      alu_src_b = (state == S_DECODE) ? d_asb : r_asb;
      wb_sel    = (state == S_DECODE) ? d_wbs : r_wbs;
      halted    = r_halted;
      fault     = r_fault;
      case (state)
        S_EXECUTE: begin
          if (r_cls == C_BRANCH) begin
            pc_write = 1'b1;
            pc_sel   = {1'b0, branch_taken};
          end
        end
        S_MEMORY: begin
          pc_write = mem_ack && (r_cls == C_STORE);
        end
        S_WRITEBACK: begin
          reg_write = r_rd_nz;
          pc_write  = 1'b1;
          pc_sel    = (r_cls == C_JAL) ? 2'd1 : (r_cls == C_JALR) ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the immediate-select (`imm_op`) input of `signext` and the register-file, ALU-source, PC and memory strobes, and it handshakes with the unified memory port. It sits between the instruction register and every datapath resource that needs per-cycle enables.

## Interface
- `DATA_WIDTH`, 32, instruction/datapath width; only 32 is supported.
- `MEM_TIMEOUT`, 64, maximum cycles `mem_req` stays high without `mem_ack` (used only with `CTRL_MEM_TIMEOUT_EN`).

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `instr` in 32: instruction register contents; valid from DECODE onward.
- `branch_taken` in 1: ALU compare result for the current branch; sampled in EXECUTE.
- `mem_ack` in 1: memory completed the request this cycle.
- `mem_req` out 1: memory request; held high until `mem_ack`.
- `mem_we` out 1: 1 = store, 0 = read; valid while `mem_req` is high.
- `ir_write` out 1: latch the fetched word into the instruction register.
- `imm_op` out 3: isa_shared immediate-select constant for `signext`.
- `alu_src_b` out 1: 0 = rs2, 1 = immediate.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4.
- `pc_write` out 1: update PC.
- `pc_sel` out 2: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR).
- `halted` out 1: sticky; core stopped.
- `fault` out 1: sticky; illegal opcode or memory timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: `mem_req`=1, `mem_we`=0. When `mem_ack`=1, assert `ir_write`=1 in that cycle and go to DECODE. Otherwise stay in FETCH.
- DECODE: classify `instr[6:0]`, then register `imm_op`, `alu_src_b`, `wb_sel` and the op class.
  - LOAD, OP-IMM, JALR → I-format (`IMM_3120`).
  - STORE → S-format; BRANCH → B-format.
  - LUI, AUIPC → U-format; JAL → J-format.
  - OP → `imm_op` don't-care; `alu_src_b`=0.
  - SYSTEM (1110011) → HALT, `halted`=1, `fault`=0.
  - Any other opcode → HALT, `halted`=1, `fault`=1.
- EXECUTE: one cycle.
  - BRANCH: `pc_write`=1, `pc_sel` = `branch_taken` ? 1 : 0, then FETCH.
  - LOAD, STORE → MEMORY. All others → WRITEBACK.
- MEMORY: `mem_req`=1, `mem_we` = (STORE).
  - On `mem_ack`, LOAD → WRITEBACK.
  - On `mem_ack`, STORE: `pc_write`=1, `pc_sel`=0, then FETCH.
- WRITEBACK: `reg_write` = (`instr[11:7]` ≠ 0), `pc_write`=1.
  - `pc_sel`: JAL=1, JALR=2, otherwise 0.
  - `wb_sel`: JAL/JALR=2, LOAD=1, otherwise 0.
  - Then FETCH.
- HALT: every strobe 0. Leaves only on `rst`.
- Decoded fields are held constant from the cycle after DECODE until the next DECODE.
- `mem_ack` is ignored while `mem_req`=0.

## Timing
- While `rst`=1: every output is 0 and the state register loads FETCH. `halted`, `fault`, decoded fields and the timeout counter clear.
- The first cycle after `rst` falls is FETCH with `mem_req`=1.
- Strobes decode combinationally from the state and registered fields; no output depends combinationally on `instr` except in DECODE.
- Minimum cycles per instruction, with `mem_ack` in the first request cycle:
  - branch 3;
  - ALU, LUI, AUIPC, JAL, JALR 4;
  - store 4;
  - load 5.
- Each memory wait cycle adds exactly one cycle.
- `mem_req` falls in the cycle after `mem_ack`. Back-to-back FETCH requests are separated by at least two cycles.
- `rst` mid-instruction, including mid-MEMORY: the request is abandoned with no `pc_write` or `reg_write` issued.

## Configuration
- `CTRL_MEM_TIMEOUT_EN` defined: a counter increments each cycle `mem_req`=1 and `mem_ack`=0, and clears on ack or on a state change. When it reaches `MEM_TIMEOUT`, the next state is HALT with `fault`=1 and `halted`=1.
- Not defined: no counter is built, FETCH/MEMORY wait indefinitely, and `MEM_TIMEOUT` is unused.

## Test plan
- `instr`=0x00500093 (addi x1,x0,5), ack immediate → `imm_op`=`IMM_3120`, `alu_src_b`=1, `reg_write`=1, `wb_sel`=0, `pc_sel`=0 in cycle 4; next FETCH in cycle 5.
- `instr`=0x0000A103 (lw x2,0(x1)), ack delayed 3 cycles in MEMORY → `mem_we`=0, `mem_req` high 4 cycles; `reg_write`=1, `wb_sel`=1 in WRITEBACK; total 8 cycles.
- BEQ 0x00208463 with `branch_taken`=1, then =0 → `pc_write`=1 in EXECUTE with `pc_sel`=1, then 0; `reg_write` never 1.
- `instr`=0xFFFFFFFF → HALT after DECODE, `fault`=1, `halted`=1, no further `mem_req`; `rst` clears both and restarts FETCH.
- With the macro and `MEM_TIMEOUT`=4, `mem_ack` held 0 in FETCH → HALT after 4 request cycles with `fault`=1. Without the macro, `mem_req` is still 1 after 100 cycles.
- `rst` pulsed during MEMORY of sw 0x0020A023 → next cycle all outputs 0, then FETCH, with no `pc_write` issued.
